// File: rtl/board_state_tracker_pkg.sv
// rtl/board_state_tracker_pkg.sv - shared types and helpers for the board-state tracker
package board_state_tracker_pkg;

  // Colour encoding on cmd_player and side_to_move.
  typedef enum logic {
    BLACK = 1'b0,
    WHITE = 1'b1
  } color_e;

  // Piece slot assignment within one colour's register file.
  typedef enum logic [3:0] {
    PC_K1 = 4'd0,  PC_Q1 = 4'd1,  PC_B2 = 4'd2,  PC_B1 = 4'd3,
    PC_N2 = 4'd4,  PC_N1 = 4'd5,  PC_R2 = 4'd6,  PC_R1 = 4'd7,
    PC_P8 = 4'd8,  PC_P7 = 4'd9,  PC_P6 = 4'd10, PC_P5 = 4'd11,
    PC_P4 = 4'd12, PC_P3 = 4'd13, PC_P2 = 4'd14, PC_P1 = 4'd15
  } piece_e;

  typedef enum logic [1:0] {
    OP_MOVE    = 2'd0,
    OP_UNDO    = 2'd1,
    OP_NEWGAME = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_TURN  = 3'd1,
    ERR_DEAD  = 3'd2,
    ERR_SELF  = 3'd3,
    ERR_EMPTY = 3'd4,
    ERR_BADOP = 3'd5
  } err_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // History entry is {player, piece, from_sq, cap_flag, cap_idx}.
  function automatic int hist_entry_w(input int idx_w, input int sq_w);
    return 1 + idx_w + sq_w + 1 + idx_w;
  endfunction

endpackage

// File: rtl/board_state_tracker_if.sv
// rtl/board_state_tracker_if.sv - command handshake bundle for the board-state tracker
interface board_state_tracker_if #(
  parameter int IDX_W = 4,
  parameter int SQ_W  = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_player;
  logic [IDX_W-1:0] cmd_piece;
  logic [SQ_W-1:0]  cmd_dest;

  modport master (
    output cmd_valid, cmd_op, cmd_player, cmd_piece, cmd_dest,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_player, cmd_piece, cmd_dest,
    output cmd_ready
  );
endinterface

// File: rtl/board_state_tracker_hist_stack.sv
// rtl/board_state_tracker_hist_stack.sv - circular LIFO of move records, oldest overwritten when full
module board_state_tracker_hist_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     top_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CNT_W-1:0] count_q, count_d;

  // ptr_q is the next write slot; the newest entry sits one slot below it.
  // When full, the next write slot is the oldest entry, so a push overwrites it.
  assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;
  assign top_o   = mem_q[ptr_dec];
  assign count_o = count_q;

  // Pointer and occupancy update; count saturates at DEPTH on push.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (clear_i) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push_i) begin
      ptr_d   = ptr_inc;
      count_d = (count_q == CNT_FULL) ? count_q : count_q + 1'b1;
    end else if (pop_i && (count_q != '0)) begin
      ptr_d   = ptr_dec;
      count_d = count_q - 1'b1;
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents beyond count are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/board_state_tracker.sv
// rtl/board_state_tracker.sv - two-colour board register file with MOVE/UNDO/NEWGAME commands
module board_state_tracker
  import board_state_tracker_pkg::*;
#(
  parameter int PIECES     = 16,
  parameter int SQ_W       = 6,
  parameter int HIST_DEPTH = 8,
  parameter logic [PIECES*SQ_W-1:0] INIT_LOC_W = 96'h20928B30D38F0070460850C4,
  parameter logic [PIECES*SQ_W-1:0] INIT_LOC_B = 96'hC31CB3D35DB7E3FE7EEBDEFC,
  localparam int IDX_W = $clog2(PIECES),
  localparam int HC_W  = $clog2(HIST_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   RST,
  board_state_tracker_if.slave   cmd,
  output logic [PIECES*SQ_W-1:0] loc_w,
  output logic [PIECES*SQ_W-1:0] loc_b,
  output logic [PIECES-1:0]      alive_w,
  output logic [PIECES-1:0]      alive_b,
  output logic                   side_to_move,
  output logic [HC_W-1:0]        hist_count,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             err_code
);

  localparam int HE_W = hist_entry_w(IDX_W, SQ_W);

  state_e                  state_q, state_d;
  op_e                     op_q;
  logic                    player_q;
  logic [IDX_W-1:0]        piece_q;
  logic [SQ_W-1:0]         dest_q;
  logic [PIECES*SQ_W-1:0]  loc_w_q, loc_w_d, loc_b_q, loc_b_d;
  logic [PIECES-1:0]       alive_w_q, alive_w_d, alive_b_q, alive_b_d;
  logic                    side_q, side_d;
  logic                    done_q, done_d, err_q, err_d;
  err_e                    err_code_q, err_code_d;
  logic                    accept;

  logic [PIECES*SQ_W-1:0]  own_loc, opp_loc;
  logic [PIECES-1:0]       own_alive, opp_alive, own_hit, opp_hit;
  logic [SQ_W-1:0]         from_sq;
  logic                    mover_alive, cap_flag;
  logic [IDX_W-1:0]        cap_idx;
  err_e                    move_code;

  logic                    push, pop, clear;
  logic [HE_W-1:0]         push_data, hist_top;
  logic [HC_W-1:0]         hist_cnt;
  logic                    ent_player, ent_cap;
  logic [IDX_W-1:0]        ent_piece, ent_capidx;
  logic [SQ_W-1:0]         ent_from;

  assign cmd.cmd_ready = (state_q == ST_IDLE) && !RST;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one EXEC cycle per accepted command.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch command fields at the accept edge so the bus is free during EXEC.
  always_ff @(posedge clk) begin
    if (RST) begin
      op_q     <= OP_MOVE;
      player_q <= 1'b0;
      piece_q  <= '0;
      dest_q   <= '0;
    end else if (accept) begin
      op_q     <= op_e'(cmd.cmd_op);
      player_q <= cmd.cmd_player;
      piece_q  <= cmd.cmd_piece;
      dest_q   <= cmd.cmd_dest;
    end
  end

  assign own_loc   = player_q ? loc_w_q   : loc_b_q;
  assign opp_loc   = player_q ? loc_b_q   : loc_w_q;
  assign own_alive = player_q ? alive_w_q : alive_b_q;
  assign opp_alive = player_q ? alive_b_q : alive_w_q;

  // Per-piece destination comparators; only alive pieces can block or be captured.
  for (genvar i = 0; i < PIECES; i++) begin : g_cmp
    assign own_hit[i] = own_alive[i] && (own_loc[i*SQ_W +: SQ_W] == dest_q)
                        && (piece_q != IDX_W'(i));
    assign opp_hit[i] = opp_alive[i] && (opp_loc[i*SQ_W +: SQ_W] == dest_q);
  end

  assign from_sq     = own_loc[piece_q*SQ_W +: SQ_W];
  assign mover_alive = own_alive[piece_q];
  assign cap_flag    = |opp_hit;

  // Priority encoder: scan high to low so the lowest hitting index wins.
  always_comb begin
    cap_idx = '0;
    for (int i = PIECES - 1; i >= 0; i--) begin
      if (opp_hit[i]) cap_idx = IDX_W'(i);
    end
  end

  // MOVE legality in priority order: turn, mover alive, own-piece collision.
  always_comb begin
    move_code = ERR_NONE;
    if (player_q != side_q)  move_code = ERR_TURN;
    else if (!mover_alive)   move_code = ERR_DEAD;
    else if (|own_hit)       move_code = ERR_SELF;
  end

  assign push_data = {player_q, piece_q, from_sq, cap_flag, cap_idx};
  assign {ent_player, ent_piece, ent_from, ent_cap, ent_capidx} = hist_top;

  // Command execution: architectural next state computed during EXEC.
  always_comb begin
    loc_w_d    = loc_w_q;
    loc_b_d    = loc_b_q;
    alive_w_d  = alive_w_q;
    alive_b_d  = alive_b_q;
    side_d     = side_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    if (state_q == ST_EXEC) begin
      done_d = 1'b1;
      case (op_q)
        OP_MOVE: begin
          if (move_code != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = move_code;
          end else begin
            err_code_d = ERR_NONE;
            push       = 1'b1;
            side_d     = ~side_q;
            if (player_q) begin
              loc_w_d[piece_q*SQ_W +: SQ_W] = dest_q;
              if (cap_flag) alive_b_d[cap_idx] = 1'b0;
            end else begin
              loc_b_d[piece_q*SQ_W +: SQ_W] = dest_q;
              if (cap_flag) alive_w_d[cap_idx] = 1'b0;
            end
          end
        end
        OP_UNDO: begin
          if (hist_cnt == '0) begin
            err_d      = 1'b1;
            err_code_d = ERR_EMPTY;
          end else begin
            err_code_d = ERR_NONE;
            pop        = 1'b1;
            side_d     = ent_player;
            if (ent_player) begin
              loc_w_d[ent_piece*SQ_W +: SQ_W] = ent_from;
              if (ent_cap) alive_b_d[ent_capidx] = 1'b1;
            end else begin
              loc_b_d[ent_piece*SQ_W +: SQ_W] = ent_from;
              if (ent_cap) alive_w_d[ent_capidx] = 1'b1;
            end
          end
        end
        OP_NEWGAME: begin
          err_code_d = ERR_NONE;
          clear      = 1'b1;
          loc_w_d    = INIT_LOC_W;
          loc_b_d    = INIT_LOC_B;
          alive_w_d  = '1;
          alive_b_d  = '1;
          side_d     = WHITE;
        end
        default: begin
          err_d      = 1'b1;
          err_code_d = ERR_BADOP;
        end
      endcase
    end
  end

  // Architectural state and status registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (RST) begin
      loc_w_q    <= INIT_LOC_W;
      loc_b_q    <= INIT_LOC_B;
      alive_w_q  <= '1;
      alive_b_q  <= '1;
      side_q     <= WHITE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      loc_w_q    <= loc_w_d;
      loc_b_q    <= loc_b_d;
      alive_w_q  <= alive_w_d;
      alive_b_q  <= alive_b_d;
      side_q     <= side_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  board_state_tracker_hist_stack #(
    .DEPTH (HIST_DEPTH),
    .W     (HE_W)
  ) u_hist (
    .clk     (clk),
    .RST     (RST),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_data),
    .top_o   (hist_top),
    .count_o (hist_cnt)
  );

  assign loc_w        = loc_w_q;
  assign loc_b        = loc_b_q;
  assign alive_w      = alive_w_q;
  assign alive_b      = alive_b_q;
  assign side_to_move = side_q;
  assign hist_count   = hist_cnt;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_board_state_tracker.sv
// tb/tb_board_state_tracker.sv - directed self-checking bench for board_state_tracker
module tb_board_state_tracker;

  localparam logic [95:0] INIT_W = 96'h20928B30D38F0070460850C4;
  localparam logic [95:0] INIT_B = 96'hC31CB3D35DB7E3FE7EEBDEFC;

  logic        clk;
  logic        RST;
  logic [95:0] loc_w, loc_b;
  logic [15:0] alive_w, alive_b;
  logic        side_to_move;
  logic [3:0]  hist_count;
  logic        done, err;
  logic [2:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  board_state_tracker_if #(.IDX_W(4), .SQ_W(6)) bus ();

  board_state_tracker dut (
    .clk          (clk),
    .RST          (RST),
    .cmd          (bus),
    .loc_w        (loc_w),
    .loc_b        (loc_b),
    .alive_w      (alive_w),
    .alive_b      (alive_b),
    .side_to_move (side_to_move),
    .hist_count   (hist_count),
    .done         (done),
    .err          (err),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic       pl;
    logic [3:0] pc;
    logic [5:0] ds;
    logic       e_err;
    logic [2:0] e_code;
    logic       e_side;
    logic [3:0] e_hc;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(int op, int pl, int pc, int ds, int e, int c, int s, int h);
    vec_t v;
    v.op = 2'(op); v.pl = 1'(pl); v.pc = 4'(pc); v.ds = 6'(ds);
    v.e_err = 1'(e); v.e_code = 3'(c); v.e_side = 1'(s); v.e_hc = 4'(h);
    return v;
  endfunction

  function automatic logic [5:0] fld(input logic [95:0] v, input int i);
    return v[i*6 +: 6];
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Issue one command and check done is low during EXEC and high the cycle after.
  task automatic send(input logic [1:0] op, input logic pl, input logic [3:0] pc, input logic [5:0] ds);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: cmd_ready stayed %b", bus.cmd_ready);
      return;
    end
    bus.cmd_op = op; bus.cmd_player = pl; bus.cmd_piece = pc; bus.cmd_dest = ds;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("done_during_exec", done, 0);
    @(posedge clk); #1;
    chk("done_after_exec", done, 1);
  endtask

  task automatic expect_status(input string tag, input logic e_err, input logic [2:0] e_code,
                               input logic e_side, input logic [3:0] e_hc);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_code"}, err_code, e_code);
    chk({tag, "_side"}, side_to_move, e_side);
    chk({tag, "_hc"}, hist_count, e_hc);
  endtask

  initial begin
    logic [95:0] exp_w, exp_b;
    logic        pl;
    logic [3:0]  pc;
    logic [5:0]  ds;

    RST = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_player = 1'b0;
    bus.cmd_piece = 4'd0; bus.cmd_dest = 6'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_low", bus.cmd_ready, 0);
    chk("rst_loc_w", loc_w, INIT_W);
    chk("rst_loc_b", loc_b, INIT_B);
    chk("rst_alive_w", alive_w, 16'hFFFF);
    chk("rst_alive_b", alive_b, 16'hFFFF);
    chk("rst_side", side_to_move, 1);
    chk("rst_hc", hist_count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    @(negedge clk);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", bus.cmd_ready, 1);

    // Directed table: op, player, piece, dest, err, code, side, hist_count
    vt[0]  = mk(0, 1, 11, 28, 0, 0, 0, 1);
    vt[1]  = mk(0, 1, 11, 28, 1, 1, 0, 1);
    vt[2]  = mk(0, 0, 12, 35, 0, 0, 1, 2);
    vt[3]  = mk(0, 1,  1, 35, 0, 0, 0, 3);
    vt[4]  = mk(1, 0,  0,  0, 0, 0, 1, 2);
    vt[5]  = mk(0, 1,  7,  1, 1, 3, 1, 2);
    vt[6]  = mk(3, 0,  0,  0, 1, 5, 1, 2);
    vt[7]  = mk(0, 0,  0, 40, 1, 1, 1, 2);
    vt[8]  = mk(0, 1,  1, 35, 0, 0, 0, 3);
    vt[9]  = mk(0, 0, 12, 36, 1, 2, 0, 3);
    vt[10] = mk(0, 0, 11, 35, 0, 0, 1, 4);
    vt[11] = mk(0, 1, 11, 35, 0, 0, 0, 5);
    vt[12] = mk(0, 0,  3, 35, 0, 0, 1, 6);
    vt[13] = mk(1, 0,  0,  0, 0, 0, 0, 5);

    for (int i = 0; i < 14; i++) begin
      send(vt[i].op, vt[i].pl, vt[i].pc, vt[i].ds);
      expect_status($sformatf("v%0d", i), vt[i].e_err, vt[i].e_code, vt[i].e_side, vt[i].e_hc);
      if (vt[i].op == 2'd0 && !vt[i].e_err)
        chk($sformatf("v%0d_mover_sq", i),
            vt[i].pl ? fld(loc_w, vt[i].pc) : fld(loc_b, vt[i].pc), vt[i].ds);
      case (i)
        1:  chk("v1_unchanged", fld(loc_w, 11), 28);
        3:  begin chk("v3_alive_b", alive_b, 16'hEFFF); chk("v3_alive_w", alive_w, 16'hFFFF); end
        4:  begin chk("v4_q_back", fld(loc_w, 1), 3); chk("v4_revive", alive_b, 16'hFFFF); end
        5:  chk("v5_r1_stays", fld(loc_w, 7), 0);
        10: begin chk("v10_alive_w", alive_w, 16'hFFFD); chk("v10_alive_b", alive_b, 16'hEFFF); end
        11: chk("v11_alive_b", alive_b, 16'hE7FF);
        12: begin chk("v12_alive_w", alive_w, 16'hF7FD); chk("v12_alive_b", alive_b, 16'hE7FF); end
        13: begin chk("v13_alive_w", alive_w, 16'hFFFD); chk("v13_b1_back", fld(loc_b, 3), 58); end
        default: ;
      endcase
    end

    // NEWGAME mid-game
    send(2'd2, 1'b0, 4'd0, 6'd0);
    expect_status("newgame", 0, 0, 1, 0);
    chk("ng_loc_w", loc_w, INIT_W);
    chk("ng_loc_b", loc_b, INIT_B);
    chk("ng_alive_w", alive_w, 16'hFFFF);
    chk("ng_alive_b", alive_b, 16'hFFFF);

    // Ten single-step pawn pushes overflow the 8-deep history
    for (int m = 0; m < 10; m++) begin
      pl = (m % 2 == 0);
      pc = 4'(8 + m / 2);
      ds = pl ? fld(INIT_W, int'(pc)) + 6'd8 : fld(INIT_B, int'(pc)) - 6'd8;
      send(2'd0, pl, pc, ds);
      expect_status($sformatf("push%0d", m), 0, 0, ~pl, (m + 1 > 8) ? 4'd8 : 4'(m + 1));
    end
    for (int j = 0; j < 8; j++) begin
      send(2'd1, 1'b0, 4'd0, 6'd0);
      expect_status($sformatf("pop%0d", j), 0, 0, ((9 - j) % 2 == 0), 4'(7 - j));
    end
    send(2'd1, 1'b0, 4'd0, 6'd0);
    expect_status("pop_empty", 1, 4, 1, 0);
    exp_w = INIT_W; exp_w[8*6 +: 6] = 6'd23;
    exp_b = INIT_B; exp_b[8*6 +: 6] = 6'd47;
    chk("hist_loc_w", loc_w, exp_w);
    chk("hist_loc_b", loc_b, exp_b);
    chk("hist_alive_w", alive_w, 16'hFFFF);
    chk("hist_alive_b", alive_b, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("code_sticky", err_code, 4);
    chk("done_one_cycle", done, 0);

    // Reset asserted during EXEC drops the command
    @(negedge clk);
    bus.cmd_op = 2'd0; bus.cmd_player = 1'b1; bus.cmd_piece = 4'd13; bus.cmd_dest = 6'd17;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    RST = 1'b1;
    chk("exec_ready_low", bus.cmd_ready, 0);
    @(posedge clk); #1;
    chk("rst_exec_done", done, 0);
    @(negedge clk);
    RST = 1'b0;
    @(posedge clk); #1;
    chk("rst_exec_done2", done, 0);
    chk("rst_exec_loc_w", loc_w, INIT_W);
    chk("rst_exec_loc_b", loc_b, INIT_B);
    chk("rst_exec_hc", hist_count, 0);
    chk("rst_exec_side", side_to_move, 1);
    chk("rst_exec_code", err_code, 0);
    chk("rst_exec_ready", bus.cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
